// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - round-robin register-file write-port arbiter with pending-write scoreboard
module wb_port_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = 32,
    parameter int RW      = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*RW-1:0]   req_rd,
    input  logic [NUM_REQ*XLEN-1:0] req_data,
    input  logic                    mark_valid,
    input  logic [RW-1:0]           mark_rd,
    output logic                    wen,
    output logic [RW-1:0]           waddr,
    output logic [XLEN-1:0]         wdata,
    output logic [(2**RW)-1:0]      pending
);

    localparam int PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int NREG = 2 ** RW;

    logic [PW-1:0]      ptr;
    logic [PW-1:0]      grant_idx;
    logic               grant_any;
    logic [NUM_REQ-1:0] grant_vec;
    logic [RW-1:0]      grant_rd;
    logic [XLEN-1:0]    grant_data;
    logic [NREG-1:0]    pending_next;

    // Requester index base+off, wrapped into 0..NUM_REQ-1.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return PW'(s);
    endfunction

    // Pick the first valid requester at or after the round-robin pointer.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        grant_vec = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_any && req_valid[wrap_add(ptr, k)]) begin
                grant_any = 1'b1;
                grant_idx = wrap_add(ptr, k);
            end
        end
        grant_vec[grant_idx] = grant_any;
        grant_rd   = req_rd[int'(grant_idx)*RW +: RW];
        grant_data = req_data[int'(grant_idx)*XLEN +: XLEN];
    end

    // No handshakes complete while reset is held.
    assign req_ready = reset ? '0 : grant_vec;

    // Scoreboard next state: the completing write clears, a new issue sets (set wins), x0 never pends.
    always_comb begin
        pending_next = pending;
        if (grant_any) pending_next[grant_rd] = 1'b0;
        if (mark_valid && (mark_rd != '0)) pending_next[mark_rd] = 1'b1;
        pending_next[0] = 1'b0;
    end

    // Registered write port, pointer advance and scoreboard update.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr     <= '0;
            wen     <= 1'b0;
            waddr   <= '0;
            wdata   <= '0;
            pending <= '0;
        end else begin
            pending <= pending_next;
            if (grant_any) begin
                ptr   <= wrap_add(grant_idx, 1);
                wen   <= (grant_rd != '0);
                waddr <= grant_rd;
                wdata <= grant_data;
            end else begin
                wen <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - randomized self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;

    localparam int NUM_REQ = 3;
    localparam int XLEN    = 32;
    localparam int RW      = 5;
    localparam int NREG    = 2 ** RW;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*RW-1:0]   req_rd;
    logic [NUM_REQ*XLEN-1:0] req_data;
    logic                    mark_valid;
    logic [RW-1:0]           mark_rd;
    logic                    wen;
    logic [RW-1:0]           waddr;
    logic [XLEN-1:0]         wdata;
    logic [NREG-1:0]         pending;

    wb_port_arbiter #(.NUM_REQ(NUM_REQ), .XLEN(XLEN), .RW(RW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rd(req_rd), .req_data(req_data),
        .mark_valid(mark_valid), .mark_rd(mark_rd),
        .wen(wen), .waddr(waddr), .wdata(wdata), .pending(pending)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // reference model state
    int              m_ptr = 0;
    bit [NREG-1:0]   m_pend = '0;
    bit              m_wen = 1'b0;
    bit [RW-1:0]     m_waddr = '0;
    bit [XLEN-1:0]   m_wdata = '0;
    int              last_grant = -1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Oldest-turn-first choice: scan requesters starting at the pointer, wrapping around.
    function automatic int model_pick();
        if (reset) return -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req_valid[(m_ptr + k) % NUM_REQ]) return (m_ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input bit v, input logic [RW-1:0] rd, input logic [XLEN-1:0] d);
        req_valid[i]          = v;
        req_rd[i*RW +: RW]    = rd;
        req_data[i*XLEN +: XLEN] = d;
    endtask

    // One clock: check the grant mid-cycle, advance the model at the edge, check registered outputs.
    task automatic cycle();
        int g;
        logic [NUM_REQ-1:0] exp_ready;
        logic [RW-1:0] rd;
        @(negedge clk);
        g = model_pick();
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        @(posedge clk);
        if (reset) begin
            m_ptr = 0; m_pend = '0; m_wen = 0; m_waddr = '0; m_wdata = '0;
        end else begin
            if (g >= 0) begin
                rd = req_rd[g*RW +: RW];
                m_wen   = (rd != 0);
                m_waddr = rd;
                m_wdata = req_data[g*XLEN +: XLEN];
                m_pend[rd] = 1'b0;
                m_ptr = (g + 1) % NUM_REQ;
            end else begin
                m_wen = 1'b0;
            end
            if (mark_valid && mark_rd != 0) m_pend[mark_rd] = 1'b1;
        end
        last_grant = g;
        #1;
        check("wen",     64'(wen),     64'(m_wen));
        check("waddr",   64'(waddr),   64'(m_waddr));
        check("wdata",   64'(wdata),   64'(m_wdata));
        check("pending", 64'(pending), 64'(m_pend));
    endtask

    initial begin
        reset = 1'b1; req_valid = '0; req_rd = '0; req_data = '0;
        mark_valid = 1'b0; mark_rd = '0;
        #1;

        // reset with every requester asking
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1, RW'(i + 1), XLEN'(32'hA0 + i));
        cycle(); cycle();
        check("rst_ready", 64'(req_ready), 64'(0));
        reset = 1'b0; req_valid = '0;
        check("rst_wen", 64'(wen), 64'(0));
        check("rst_waddr", 64'(waddr), 64'(0));
        check("rst_wdata", 64'(wdata), 64'(0));
        check("rst_pending", 64'(pending), 64'(0));

        // single request from requester 1
        set_req(1, 1, 5'd7, 32'hDEADBEEF);
        @(negedge clk);
        check("single_ready", 64'(req_ready), 64'(3'b010));
        cycle();
        check("single_wen", 64'(wen), 64'(1));
        check("single_waddr", 64'(waddr), 64'(7));
        check("single_wdata", 64'(wdata), 64'(32'hDEADBEEF));
        req_valid = '0;
        cycle();
        check("single_idle_wen", 64'(wen), 64'(0));

        // round robin from pointer 0
        reset = 1'b1; cycle(); reset = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1, RW'(i + 1), XLEN'(32'h100 + i));
        for (int c = 0; c < 6; c++) begin
            cycle();
            check("rr_waddr", 64'(waddr), 64'((c % 3) + 1));
            check("rr_wen", 64'(wen), 64'(1));
        end
        req_valid = 3'b001; cycle();
        req_valid = 3'b101; cycle();
        check("rr_skip_first", 64'(waddr), 64'(3));
        req_valid = 3'b001; cycle();
        check("rr_skip_second", 64'(waddr), 64'(1));

        // write to x0
        set_req(0, 1, 5'd0, 32'h12345678); req_valid = 3'b001;
        cycle();
        check("x0_wen", 64'(wen), 64'(0));
        check("x0_waddr", 64'(waddr), 64'(0));
        check("x0_wdata", 64'(wdata), 64'(32'h12345678));
        req_valid = '0;

        // scoreboard set/clear interactions
        mark_valid = 1'b1; mark_rd = 5'd5; cycle();
        check("sb_set5", 64'(pending[5]), 64'(1));
        set_req(0, 1, 5'd5, 32'h55); req_valid = 3'b001; cycle();
        check("sb_set_wins", 64'(pending[5]), 64'(1));
        mark_rd = 5'd9; cycle();
        check("sb_clr5", 64'(pending[5]), 64'(0));
        check("sb_set9", 64'(pending[9]), 64'(1));
        req_valid = '0; mark_rd = 5'd0; cycle();
        check("sb_x0", 64'(pending[0]), 64'(0));
        mark_valid = 1'b0;

        // reset in the middle of a grant to requester 2
        mark_valid = 1'b1; mark_rd = 5'd4; cycle(); mark_valid = 1'b0;
        req_valid = 3'b010; cycle();
        set_req(2, 1, 5'd4, 32'h44); req_valid = 3'b100;
        reset = 1'b1; cycle(); reset = 1'b0;
        check("midrst_wen", 64'(wen), 64'(0));
        check("midrst_pending", 64'(pending), 64'(0));
        req_valid = 3'b111; cycle();
        check("midrst_first", 64'(last_grant), 64'(0));

        // randomized traffic with hold-until-accepted requesters
        req_valid = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] || last_grant == i) begin
                    if ($urandom_range(0, 2) != 0)
                        set_req(i, 1, RW'($urandom), XLEN'($urandom));
                    else
                        req_valid[i] = 1'b0;
                end
            end
            mark_valid = ($urandom_range(0, 1) == 1);
            mark_rd    = RW'($urandom);
            reset      = ($urandom_range(0, 49) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port among NUM_REQ result producers (ALU, load unit, CSR unit) with round-robin arbitration.
- Drives registered wen/waddr/wdata to the register file.
- Keeps a pending-write scoreboard that issue logic sets and granted writebacks clear, so decode can detect RAW hazards on in-flight destinations.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- XLEN, 32, data width.
- RW, 5, register address width (2**RW registers; register 0 is hardwired zero).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester write request
- req_ready  out  NUM_REQ  per-requester grant; acceptance when valid&ready
- req_rd  in  NUM_REQ*RW  destination register; slot i at [i*RW +: RW]
- req_data  in  NUM_REQ*XLEN  write data; slot i at [i*XLEN +: XLEN]
- mark_valid  in  1  issue stage marks a destination pending
- mark_rd  in  RW  register being marked
- wen  out  1  register-file write enable (registered)
- waddr  out  RW  register-file write address (registered)
- wdata  out  XLEN  register-file write data (registered)
- pending  out  2**RW  scoreboard bitmap; bit r=1 means a write to r is outstanding

Behaviour:
- Reset, sync on the clk edge with reset=1:
  - wen=0, waddr=0, wdata=0, pending=0.
  - RR pointer=0, so requester 0 has highest priority.
  - req_ready is combinational and is 0 while reset=1.
- Arbitration (combinational):
  - Among asserted req_valid, grant the first index at or after the pointer, searching upward modulo NUM_REQ.
  - At most one req_ready bit is high; it is high only for a valid requester.
  - req_ready does not depend on any downstream ready; the port never stalls.
- Pointer update:
  - On a grant to i, pointer <= (i+1) mod NUM_REQ at the next edge.
  - No grant: pointer holds.
- Requester rules: once valid is asserted, rd/data are held stable until ready is seen. A requester may deassert only after acceptance. Back-to-back requests from the same requester are allowed.
- Write port, 1-cycle latency from acceptance:
  - Edge after grant to i: wen <= (rd_i != 0), waddr <= rd_i, wdata <= data_i.
  - No grant: wen <= 0; waddr/wdata hold their previous values.
  - A request with rd=0 is accepted (ready=1) and consumes a grant, but produces wen=0. waddr/wdata still update.
- Scoreboard, updated at each edge:
  - Clear: on grant to i, pending[rd_i] <= 0. This takes effect at the same edge that raises wen for that write.
  - Set: mark_valid=1 and mark_rd != 0 gives pending[mark_rd] <= 1.
  - mark_rd=0 is ignored; pending[0] is always 0.
  - Same register set and cleared in the same cycle: set wins, because the new in-flight op supersedes the completing one.
  - Different registers set and cleared in the same cycle: both take effect.
  - Clearing an already-clear bit has no effect. Setting an already-set bit has no effect.
  - No counting: multiple outstanding writes to one register are the issue stage's responsibility to prevent.
- Reset mid-operation:
  - Any in-flight grant is dropped; no write occurs at the reset edge.
  - All pending bits clear and the pointer returns to 0.
- Throughput: one write per cycle sustained under any request pattern. With all NUM_REQ requesters continuously valid, each is granted exactly once every NUM_REQ cycles.

Test Plan:
- Reset: assert reset with all req_valid=1 -> req_ready=0; after release, wen=0, waddr=0, wdata=0, pending=0.
- Single request: req 1 valid, rd=7, data=0xDEADBEEF -> req_ready=3'b010 that cycle; next cycle wen=1, waddr=7, wdata=0xDEADBEEF; following cycle wen=0.
- Round robin: all 3 valid continuously, rd=1/2/3 -> grant order 0,1,2,0,1,2; waddr sequence 1,2,3,1,2,3, one per cycle. With only req 0 and req 2 valid after pointer=1 -> req 2 granted first, then req 0.
- x0 write: req 0 valid, rd=0, data=0x12345678 -> ready=1; next cycle wen=0, waddr=0, wdata=0x12345678; pending unchanged.
- Scoreboard: mark_rd=5 -> pending[5]=1. Later, same cycle as a grant with rd=5, mark_rd=5 -> pending[5] stays 1. Grant rd=5 with mark_rd=9 -> pending[5]=0 and pending[9]=1. mark_rd=0 -> pending[0] stays 0.
- Reset mid-stream: reset during cycle of grant to req 2, rd=4, with pending[4]=1 -> next cycle wen=0, pending=0; first grant after release goes to req 0 when all valid.
